pipemwreg_elastic: RTL
======================

# pipemwreg_elastic

Parametrised MEM/WB pipeline register with a valid/ready handshake, a two-entry skid buffer, and a synchronous flush. It sits between the MEM and WB stages and carries the same bundle as the fixed MEM/WB latch: register-write enable, memory-to-register select, destination register number, ALU result and memory output. Backpressure from WB is absorbed without losing or duplicating instructions, and full throughput is kept with a registered `in_ready`.

## Interface
Parameters:
- `DATA_W`, default 32: width of the ALU-result and memory-output fields.
- `RN_W`, default 5: width of the destination-register number.

Ports:
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  reset is synchronous and active-high; one clock; clears all state.
- `flush`  in  1  synchronous kill of all held entries.
- `in_valid`  in  1  MEM presents a bundle.
- `in_ready`  out  1  stage can accept; registered, no combinational path from `out_ready`.
- `mwreg`, `mm2reg`  in  1 each  MEM-side control bits.
- `mrn`  in  RN_W  MEM destination register.
- `malu`, `mmo`  in  DATA_W each  MEM ALU result and memory data.
- `out_valid`  out  1  WB bundle valid.
- `out_ready`  in  1  WB accepts.
- `wwreg`, `wm2reg`  out  1 each  held control bits.
- `wrn`  out  RN_W  held destination register.
- `walu`, `wmo`  out  DATA_W each  held data.
- `wdata`  out  DATA_W  write-back value: `wmo` when `wm2reg`=1, otherwise `walu`.
- `wen`  out  1  `out_valid & out_ready & wwreg`; the only legal register-file write strobe.

## Operation
- Storage: one main entry that drives the outputs, plus one skid entry. Each entry has a valid bit.
- Occupancy states:
  - EMPTY: no valid entry.
  - ONE: only the main entry is valid.
  - TWO: both entries are valid.
- Handshake signals:
  - `in_ready` = !skid_valid.
  - `out_valid` = main_valid.
  - An input fire is `in_valid & in_ready`; an output fire is `out_valid & out_ready`.
- Transitions:
  - EMPTY, input fire → ONE; main loads the input.
  - ONE, input fire and output fire → ONE; main loads the input.
  - ONE, input fire and no output fire → TWO; skid loads the input.
  - ONE, output fire and no input fire → EMPTY.
  - TWO, output fire → ONE; main loads skid, skid is cleared. No input is accepted in TWO.
- Ordering: strictly FIFO. An entry is never emitted twice and never dropped, except by `flush` or `reset`.
- `flush`:
  - Next state is EMPTY regardless of any input or output fire in the same cycle; the incoming bundle is discarded.
  - `wen` is still computed combinationally from the pre-flush `out_valid` in the flush cycle, so a bundle handshaking out in that cycle does commit.
- `reset` has priority over `flush`.
- Payload fields are opaque and are not modified. `wdata` is a pure mux of the main entry.

## Timing
- Latency: input fire in cycle N gives `out_valid` in cycle N+1 when the stage was EMPTY or ONE with an output fire.
- Throughput: one bundle per cycle while `out_ready` stays high.
- `in_ready` falls in the cycle after the skid fills and rises in the cycle after TWO drains to ONE.
- Reset values: `out_valid`=0, `in_ready`=1, `wwreg`=0, `wm2reg`=0, `wrn`=0, `walu`=0, `wmo`=0, `wdata`=0, `wen`=0. Skid contents are 0.
- Reset asserted mid-transfer: in-flight entries are lost; the state is EMPTY on the next edge.
- Flush values: `out_valid`=0 and `in_ready`=1 on the next edge. Payload registers may retain stale data; they are qualified by `out_valid`.

## Configuration
- `PIPEMW_FWD_EN` defined:
  - Adds inputs `rs`, `rt` (RN_W each) and outputs `fwd_a`, `fwd_b` (1 each), plus `fwd_data` (DATA_W, equal to `wdata`).
  - `fwd_a` = `out_valid & wwreg & (wrn != 0) & (wrn == rs)`; `fwd_b` is the same with `rt`.
  - These are combinational from the main entry only; the skid entry is never forwarded.
- Macro undefined: these ports and their logic are absent; all other behaviour is identical.

## Structure
- Shared package `pipe_pkg`:
  - Struct `mw_bundle_t` with fields wreg, m2reg, rn, alu, mo.
  - Default widths `DATA_W` and `RN_W`.
  - Occupancy state enum: EMPTY, ONE, TWO.
- Sub-module `pipe_skid_buf`: generic over the bundle type. It contains the main/skid registers and the state machine. The top level adds the `wdata` and `wen` logic and the forwarding logic.

## Test plan
- Streaming: reset, then 8 bundles with `malu`=1..8 and `out_ready` held at 1 → `walu` shows 1..8 on consecutive cycles starting one cycle after the first fire; `in_ready` stays 1.
- Backpressure:
  - Feed `malu`=0xA, 0xB, 0xC while `out_ready`=0 → 0xA and 0xB are held, `in_ready`=0 after 0xB, and 0xC stalls.
  - Raise `out_ready` → output order is 0xA, 0xB, 0xC with no duplicates.
- Write-back select and enable:
  - `mm2reg`=1, `mmo`=0x1234, `malu`=0x5678, `mwreg`=1, `mrn`=7, `out_ready`=1 → `wdata`=0x1234, `wen`=1 for one cycle, `wrn`=7.
  - `mwreg`=0 → `wen`=0.
- Flush:
  - In state TWO, assert `flush` together with `in_valid`=1 → next cycle `out_valid`=0, `in_ready`=1, `wen`=0.
  - The flushed input never appears at the output.
- Reset: assert `reset` in state TWO with `in_valid`=1 → all outputs take their reset values on the next edge; the first post-reset input appears after 1 cycle.
- With `PIPEMW_FWD_EN`:
  - Held `wrn`=5, `wwreg`=1, `rs`=5, `rt`=0 → `fwd_a`=1, `fwd_b`=0.
  - `wrn`=0 with `rs`=0 → `fwd_a`=0.
  - `out_valid`=0 → both forwarding outputs are 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the elastic MEM/WB register: bundle layout, default widths, occupancy states.
package pipe_pkg;
    localparam int DATA_W = 32;
    localparam int RN_W   = 5;

    typedef struct packed {
        logic              wreg;
        logic              m2reg;
        logic [RN_W-1:0]   rn;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] mo;
    } mw_bundle_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;
endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer (main + skid) over an arbitrary bundle type; in_ready is a pure
// function of registered occupancy, so there is no combinational path from out_ready.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter type T = mw_bundle_t
) (
    input  logic clock,
    input  logic reset,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);
    occ_t state;
    T     main_q;
    T     skid_q;
    logic in_fire;
    logic out_fire;

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            // Payload is left stale; it is qualified by out_valid.
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: if (in_fire) begin
                    main_q <= in_data;
                    state  <= ONE;
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (in_fire) begin
                        skid_q <= in_data;
                        state  <= TWO;
                    end else if (out_fire) begin
                        state <= EMPTY;
                    end
                end
                TWO: if (out_fire) begin
                    main_q <= skid_q;
                    skid_q <= '0;
                    state  <= ONE;
                end
                default: state <= EMPTY;
            endcase
        end
    end
endmodule

// File: rtl/pipemwreg_elastic.sv
// Elastic MEM/WB pipeline register with write-back mux and commit strobe.
// Define PIPEMW_FWD_EN to add WB->EX forwarding compare outputs.
module pipemwreg_elastic #(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int RN_W   = pipe_pkg::RN_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mwreg,
    input  logic              mm2reg,
    input  logic [RN_W-1:0]   mrn,
    input  logic [DATA_W-1:0] malu,
    input  logic [DATA_W-1:0] mmo,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              wwreg,
    output logic              wm2reg,
    output logic [RN_W-1:0]   wrn,
    output logic [DATA_W-1:0] walu,
    output logic [DATA_W-1:0] wmo,
    output logic [DATA_W-1:0] wdata,
`ifdef PIPEMW_FWD_EN
    input  logic [RN_W-1:0]   rs,
    input  logic [RN_W-1:0]   rt,
    output logic              fwd_a,
    output logic              fwd_b,
    output logic [DATA_W-1:0] fwd_data,
`endif
    output logic              wen
);
    import pipe_pkg::*;

    typedef struct packed {
        logic              wreg;
        logic              m2reg;
        logic [RN_W-1:0]   rn;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] mo;
    } bundle_t;

    bundle_t in_b;
    bundle_t out_b;

    assign in_b = '{wreg: mwreg, m2reg: mm2reg, rn: mrn, alu: malu, mo: mmo};

    pipe_skid_buf #(.T(bundle_t)) u_buf (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_b)
    );

    assign wwreg  = out_b.wreg;
    assign wm2reg = out_b.m2reg;
    assign wrn    = out_b.rn;
    assign walu   = out_b.alu;
    assign wmo    = out_b.mo;
    assign wdata  = out_b.m2reg ? out_b.mo : out_b.alu;
    // Uses pre-flush out_valid, so a bundle leaving in a flush cycle still commits.
    assign wen    = out_valid & out_ready & out_b.wreg;

`ifdef PIPEMW_FWD_EN
    logic hit_ok;
    assign hit_ok   = out_valid & out_b.wreg & (out_b.rn != '0);
    assign fwd_a    = hit_ok & (out_b.rn == rs);
    assign fwd_b    = hit_ok & (out_b.rn == rt);
    assign fwd_data = wdata;
`endif
endmodule
